// File: rtl/pcie_tl_switch.sv
// ============================================================================
// Module   : pcie_tl_switch
// Purpose  : NCH-port transaction-layer switch. Per-input FIFOs feed a
//            round-robin arbiter that routes packets to per-output FIFOs by
//            destination. Includes pop counters and a control FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_tl_switch #(
    parameter  int NCH    = 4,
    parameter  int DATA_W = 10,
    parameter  int DEPTH  = 8,
    parameter  int CNT_W  = 5,
    localparam int AW     = $clog2(DEPTH),
    localparam int SW     = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [AW:0]           low_thr,
    input  logic [AW:0]           high_thr,
    input  logic [NCH-1:0]        push_in,
    input  logic [NCH*DATA_W-1:0] data_in,
    output logic [NCH-1:0]        in_full,
    input  logic [NCH-1:0]        pop_out,
    output logic [NCH*DATA_W-1:0] data_out,
    output logic [NCH-1:0]        out_empty,
    output logic [NCH-1:0]        out_alm_empty,
    output logic [NCH-1:0]        out_alm_full,
    input  logic                  req,
    input  logic [SW-1:0]         idx,
    output logic [CNT_W-1:0]      count,
    output logic                  valid,
    output logic [2:0]            state,
    output logic                  error
);

    localparam logic [2:0] C_RESET  = 3'd0;
    localparam logic [2:0] C_INIT   = 3'd1;
    localparam logic [2:0] C_IDLE   = 3'd2;
    localparam logic [2:0] C_ACTIVE = 3'd3;
    localparam logic [2:0] C_ERROR  = 3'd4;

    logic [2:0]       r_state;
    logic [AW:0]      r_low;
    logic [AW:0]      r_high;
    logic [SW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;

    logic             w_run;
    logic [NCH-1:0]   w_in_empty;
    logic [NCH-1:0]   w_in_full;
    logic [NCH-1:0]   w_out_empty;
    logic [NCH-1:0]   w_out_full;
    logic [NCH-1:0]   w_out_afull;
    logic [NCH-1:0]   w_push_ok;
    logic [NCH-1:0]   w_pop_ok;
    logic [NCH-1:0]   w_elig;
    logic [NCH-1:0]   w_in_pop;
    logic [NCH-1:0]   w_out_push;
    logic [DATA_W-1:0] w_in_head [NCH];
    logic [SW-1:0]     w_in_dest [NCH];
    logic [CNT_W-1:0]  w_cnt     [NCH];
    logic              w_grant_vld;
    logic [SW-1:0]     w_grant_idx;
    logic [DATA_W-1:0] w_grant_data;
    logic [SW-1:0]     w_grant_dest;
    logic              w_err_ev;

    // Pushes and error detection are live in INIT/IDLE/ACTIVE only.
    assign w_run = (r_state == C_INIT) || (r_state == C_IDLE) || (r_state == C_ACTIVE);
    assign w_push_ok = push_in & ~w_in_full & {NCH{w_run}};
    assign w_pop_ok  = pop_out & ~w_out_empty & {NCH{r_state != C_RESET}};
    assign w_err_ev  = w_run && ((|(push_in & w_in_full)) || (|(pop_out & w_out_empty)));

    // Lowest offset from the pointer wins; loop runs high-to-low so it lands last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_elig[r_ptr + SW'(k)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = r_ptr + SW'(k);
            end
        end
    end

    assign w_grant_data = w_in_head[w_grant_idx];
    assign w_grant_dest = w_in_dest[w_grant_idx];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DATA_W-1:0] r_imem [DEPTH];
        logic [AW-1:0]     r_iwr, r_ird;
        logic [AW:0]       r_iocc;
        logic [DATA_W-1:0] r_omem [DEPTH];
        logic [AW-1:0]     r_owr, r_ord;
        logic [AW:0]       r_oocc;
        logic [CNT_W-1:0]  r_cnt;

        assign w_in_empty[i]  = (r_iocc == '0);
        assign w_in_full[i]   = (r_iocc == (AW+1)'(DEPTH));
        assign w_out_empty[i] = (r_oocc == '0);
        assign w_out_full[i]  = (r_oocc == (AW+1)'(DEPTH));
        assign w_out_afull[i] = (r_oocc >= r_high);
        assign w_in_head[i]   = r_imem[r_ird];
        assign w_in_dest[i]   = r_imem[r_ird][DATA_W-1 -: SW];
        assign w_cnt[i]       = r_cnt;
        assign w_elig[i]      = (r_state == C_ACTIVE) && !w_in_empty[i] &&
                                !w_out_full[w_in_dest[i]] && !w_out_afull[w_in_dest[i]];
        assign w_in_pop[i]    = w_grant_vld && (w_grant_idx == SW'(i));
        assign w_out_push[i]  = w_grant_vld && (w_grant_dest == SW'(i));

        assign in_full[i]                      = w_in_full[i];
        assign out_empty[i]                    = w_out_empty[i];
        assign out_alm_empty[i]                = (r_oocc <= r_low);
        assign out_alm_full[i]                 = w_out_afull[i];
        assign data_out[i*DATA_W +: DATA_W]    = r_omem[r_ord];

        always_ff @(posedge clk) begin
            if (w_push_ok[i]) r_imem[r_iwr] <= data_in[i*DATA_W +: DATA_W];
            if (w_out_push[i]) r_omem[r_owr] <= w_grant_data;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_iwr  <= '0;
                r_ird  <= '0;
                r_iocc <= '0;
                r_owr  <= '0;
                r_ord  <= '0;
                r_oocc <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push_ok[i])  r_iwr <= r_iwr + 1'b1;
                if (w_in_pop[i])   r_ird <= r_ird + 1'b1;
                r_iocc <= r_iocc + (AW+1)'(w_push_ok[i]) - (AW+1)'(w_in_pop[i]);
                if (w_out_push[i]) r_owr <= r_owr + 1'b1;
                if (w_pop_ok[i]) begin
                    r_ord <= r_ord + 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                end
                r_oocc <= r_oocc + (AW+1)'(w_out_push[i]) - (AW+1)'(w_pop_ok[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_RESET;
            r_low   <= (AW+1)'(1);
            r_high  <= (AW+1)'(DEPTH - 1);
            r_ptr   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (req && (r_state != C_RESET)) begin
                r_valid <= 1'b1;
                r_count <= w_cnt[idx];
            end
            if (w_grant_vld) r_ptr <= w_grant_idx + SW'(1);
            case (r_state)
                C_RESET: r_state <= C_INIT;
                C_INIT: begin
                    r_low  <= low_thr;
                    r_high <= high_thr;
                    // The exit check uses thresholds latched on earlier INIT cycles.
                    if (w_err_ev)               r_state <= C_ERROR;
                    else if (!init)             r_state <= (r_low >= r_high) ? C_ERROR : C_IDLE;
                end
                C_IDLE: begin
                    if (w_err_ev)               r_state <= C_ERROR;
                    else if (init)              r_state <= C_INIT;
                    else if (!(&w_in_empty))    r_state <= C_ACTIVE;
                end
                C_ACTIVE: begin
                    if (w_err_ev)               r_state <= C_ERROR;
                    else if (init)              r_state <= C_INIT;
                    else if ((&w_in_empty) && (&w_out_empty)) r_state <= C_IDLE;
                end
                C_ERROR: r_state <= C_ERROR;
                default: r_state <= C_RESET;
            endcase
        end
    end

    assign count = r_count;
    assign valid = r_valid;
    assign state = r_state;
    assign error = (r_state == C_ERROR);

endmodule

`default_nettype wire
